// File: rtl/gpioemu_host.sv
// Bus initiator that runs one gpioemu multiply/popcount job per start request:
// writes A1, A2, trigger, polls status, then reads back W and L.
module gpioemu_host #(
    parameter int STB_CYCLES = 2,
    parameter int POLL_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] arg_a,
    input  logic [23:0] arg_b,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] result_w,
    output logic [23:0] result_l,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    typedef enum logic [2:0] {
        IDLE, WR_A1, WR_A2, WR_GO, POLL, RD_W, RD_L, DONE
    } state_t;

    localparam int CW = $clog2(STB_CYCLES + 2);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [CW-1:0] CNT_STB  = CW'(STB_CYCLES);
    localparam logic [CW-1:0] CNT_END  = CW'(STB_CYCLES + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

    localparam logic [15:0] ADDR_A1   = 16'h0380;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [PW-1:0] poll_cnt;
    logic [PW-1:0] poll_cnt_inc;
    logic          poll_ok;
    logic [23:0]   b_q;
    logic          last, sample, accept, timeout_set;

    logic [15:0]   addr_nx;
    logic [31:0]   data_nx;
    logic          srd_nx, swr_nx, busy_nx, done_nx;

    // cnt walks SETUP (0), STROBE (1..STB_CYCLES), HOLD (STB_CYCLES+1)
    assign last         = (cnt == CNT_END);
    assign sample       = (cnt == CNT_STB);
    assign accept       = (state == IDLE) && start;
    assign poll_cnt_inc = poll_cnt + 1'b1;
    assign timeout_set  = (state == POLL) && last && !poll_ok && (poll_cnt_inc == POLL_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WR_A1;
                    cnt_nx   = '0;
                end
            end
            DONE: state_nx = IDLE;
            default: begin
                if (last) begin
                    cnt_nx = '0;
                    case (state)
                        WR_A1: state_nx = WR_A2;
                        WR_A2: state_nx = WR_GO;
                        WR_GO: state_nx = POLL;
                        POLL: begin
                            if (poll_ok)          state_nx = RD_W;
                            else if (timeout_set) state_nx = DONE;
                            else                  state_nx = POLL;
                        end
                        RD_W:    state_nx = RD_L;
                        RD_L:    state_nx = DONE;
                        default: state_nx = IDLE;
                    endcase
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
        endcase
    end

    // Bus outputs are a function of the next state so they come straight off flops.
    always_comb begin
        addr_nx = saddress;
        data_nx = sdata_out;
        case (state_nx)
            WR_A1:     addr_nx = ADDR_A1;
            WR_A2:     addr_nx = ADDR_A2;
            WR_GO:     addr_nx = ADDR_CTRL;
            POLL:      addr_nx = ADDR_CTRL;
            RD_W:      addr_nx = ADDR_W;
            RD_L:      addr_nx = ADDR_L;
            default:   addr_nx = saddress;
        endcase
        if (state_nx != state) begin
            case (state_nx)
                WR_A1:   data_nx = {8'h00, arg_a};
                WR_A2:   data_nx = {8'h00, b_q};
                WR_GO:   data_nx = 32'h0;
                POLL:    data_nx = 32'h0;
                default: data_nx = sdata_out;
            endcase
        end
        srd_nx  = 1'b0;
        swr_nx  = 1'b0;
        if ((cnt_nx != '0) && (cnt_nx <= CNT_STB)) begin
            srd_nx = (state_nx == POLL) || (state_nx == RD_W) || (state_nx == RD_L);
            swr_nx = (state_nx == WR_A1) || (state_nx == WR_A2) || (state_nx == WR_GO);
        end
        busy_nx = (state_nx != IDLE) && (state_nx != DONE);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            saddress  <= '0;
            sdata_out <= '0;
            srd       <= 1'b0;
            swr       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            result_w  <= '0;
            result_l  <= '0;
            poll_cnt  <= '0;
            poll_ok   <= 1'b0;
            b_q       <= '0;
        end else begin
            saddress  <= addr_nx;
            sdata_out <= data_nx;
            srd       <= srd_nx;
            swr       <= swr_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            if (accept) begin
                b_q      <= arg_b;
                result_w <= '0;
                result_l <= '0;
                timeout  <= 1'b0;
                poll_cnt <= '0;
            end else begin
                if (timeout_set) timeout <= 1'b1;
                if ((state == POLL) && last && !poll_ok) poll_cnt <= poll_cnt_inc;
            end
            if ((state == POLL) && sample) poll_ok  <= (sdata_in[1:0] == 2'b11);
            if ((state == RD_W) && sample) result_w <= sdata_in;
            if ((state == RD_L) && sample) result_l <= sdata_in[23:0];
        end
    end

endmodule

// File: tb/tb_gpioemu_host.sv
// Directed bench for gpioemu_host with a behavioural gpioemu peripheral on the bus.
module tb_gpioemu_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] arg_a, arg_b;
    logic        busy, done, timeout, srd, swr;
    logic [31:0] result_w, sdata_out, sdata_in;
    logic [23:0] result_l;
    logic [15:0] saddress;

    int n_assert = 0;
    int n_fail   = 0;

    gpioemu_host #(.STB_CYCLES(2), .POLL_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .arg_a(arg_a), .arg_b(arg_b),
        .busy(busy), .done(done), .timeout(timeout), .result_w(result_w),
        .result_l(result_l), .saddress(saddress), .srd(srd), .swr(swr),
        .sdata_out(sdata_out), .sdata_in(sdata_in)
    );

    always #5 clk = ~clk;

    // Peripheral model: logs every strobe, computes W = A1*A2, L = popcount(W).
    logic        log_wr   [256];
    logic [15:0] log_addr [256];
    logic [31:0] log_dat  [256];
    int          log_n    = 0;
    int          n_stat   = 0;
    int          stat_base = 0;
    int          fail_polls = 0;
    logic [23:0] reg_a1 = '0, reg_a2 = '0;
    logic [47:0] prod;

    initial sdata_in = '0;

    always @(posedge swr) begin
        if (log_n < 256) begin
            log_wr[log_n] = 1'b1; log_addr[log_n] = saddress; log_dat[log_n] = sdata_out;
            log_n++;
        end
        if (saddress == 16'h0380) reg_a1 = sdata_out[23:0];
        if (saddress == 16'h0388) reg_a2 = sdata_out[23:0];
    end

    always @(posedge srd) begin
        if (log_n < 256) begin
            log_wr[log_n] = 1'b0; log_addr[log_n] = saddress; log_dat[log_n] = '0;
            log_n++;
        end
        prod = reg_a1 * reg_a2;
        case (saddress)
            16'h03A0: begin
                sdata_in = ((n_stat - stat_base) < fail_polls) ? 32'h1 : 32'h3;
                n_stat++;
            end
            16'h0390: sdata_in = prod[31:0];
            16'h0398: sdata_in = 32'($countones(prod[31:0]));
            default:  sdata_in = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ent(input int k);
        return 64'({log_wr[k], log_addr[k], log_wr[k] ? log_dat[k] : 32'h0});
    endfunction

    function automatic int count_reads(input int from, input logic [15:0] addr);
        int c = 0;
        for (int k = from; k < log_n; k++)
            if (!log_wr[k] && log_addr[k] == addr) c++;
        return c;
    endfunction

    // Starts a job at cycle 0 and returns the cycle index at which done is seen.
    task automatic run_job(input logic [23:0] a, input logic [23:0] b, input int fails,
                           input bit restart, output int done_cyc, output int base);
        fail_polls = fails;
        stat_base  = n_stat;
        base       = log_n;
        done_cyc   = -1;
        @(posedge clk); #1;
        arg_a = a; arg_b = b; start = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            start = restart && (i == 10);
            if (i == 1) chk("busy_cycle1", 64'(busy), 64'd1);
            if (done) begin
                done_cyc = i;
                break;
            end
        end
        chk("busy_low_at_done", 64'(busy), 64'd0);
    endtask

    int dc, base, pulses;

    initial begin
        reset = 1'b1; start = 1'b0; arg_a = '0; arg_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus", 64'({saddress, sdata_out, srd, swr}), 64'd0);
        chk("rst_status", 64'({busy, done, timeout}), 64'd0);
        chk("rst_results", 64'({result_w, result_l}), 64'd0);
        reset = 1'b0;

        // Basic job, first poll succeeds
        run_job(24'd3, 24'd5, 0, 1'b0, dc, base);
        chk("job1_done_cycle", 64'(dc), 64'd25);
        chk("job1_w", 64'(result_w), 64'd15);
        chk("job1_l", 64'(result_l), 64'd4);
        chk("job1_timeout", 64'(timeout), 64'd0);
        chk("job1_trace_len", 64'(log_n - base), 64'd6);
        chk("job1_tr0", ent(base + 0), 64'({1'b1, 16'h0380, 32'h3}));
        chk("job1_tr1", ent(base + 1), 64'({1'b1, 16'h0388, 32'h5}));
        chk("job1_tr2", ent(base + 2), 64'({1'b1, 16'h03A0, 32'h0}));
        chk("job1_tr3", ent(base + 3), 64'({1'b0, 16'h03A0, 32'h0}));
        chk("job1_tr4", ent(base + 4), 64'({1'b0, 16'h0390, 32'h0}));
        chk("job1_tr5", ent(base + 5), 64'({1'b0, 16'h0398, 32'h0}));
        @(posedge clk); #1;
        chk("job1_done_pulse", 64'(done), 64'd0);
        chk("job1_w_hold", 64'(result_w), 64'd15);

        // Maximum operands
        run_job(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0, dc, base);
        chk("max_done_cycle", 64'(dc), 64'd25);
        chk("max_w", 64'(result_w), 64'hFE000001);
        chk("max_l", 64'(result_l), 64'd8);

        // Three pending polls, then complete
        run_job(24'd2, 24'd3, 3, 1'b0, dc, base);
        chk("slow_done_cycle", 64'(dc), 64'd37);
        chk("slow_status_reads", 64'(n_stat - stat_base), 64'd4);
        chk("slow_w", 64'(result_w), 64'd6);
        chk("slow_l", 64'(result_l), 64'd2);
        chk("slow_timeout", 64'(timeout), 64'd0);

        // Status never completes: timeout after POLL_LIMIT reads
        run_job(24'd7, 24'd9, 1000, 1'b0, dc, base);
        chk("to_done_cycle", 64'(dc), 64'd29);
        chk("to_timeout", 64'(timeout), 64'd1);
        chk("to_results", 64'({result_w, result_l}), 64'd0);
        chk("to_status_reads", 64'(n_stat - stat_base), 64'd4);
        chk("to_w_l_reads", 64'(count_reads(base, 16'h0390) + count_reads(base, 16'h0398)), 64'd0);

        // Second start while busy is ignored
        run_job(24'd3, 24'd5, 0, 1'b1, dc, base);
        chk("rs_done_cycle", 64'(dc), 64'd25);
        chk("rs_w", 64'(result_w), 64'd15);
        chk("rs_timeout", 64'(timeout), 64'd0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        chk("rs_no_second_job", 64'(pulses), 64'd0);
        chk("rs_trace_len", 64'(log_n - base), 64'd6);

        // Reset during the STROBE phase of WR_A2
        @(posedge clk); #1;
        arg_a = 24'd3; arg_b = 24'd5; start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("mid_swr_before", 64'({swr, saddress}), 64'({1'b1, 16'h0388}));
        reset = 1'b1;
        #1;
        chk("mid_rst_strobes_busy", 64'({srd, swr, busy}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("mid_no_done", 64'(pulses), 64'd0);
        chk("mid_results_clear", 64'({result_w, result_l, timeout}), 64'd0);
        run_job(24'd7, 24'd9, 0, 1'b0, dc, base);
        chk("post_done_cycle", 64'(dc), 64'd25);
        chk("post_w", 64'(result_w), 64'd63);
        chk("post_l", 64'(result_l), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Protocol invariants checked every cycle away from the clock edge
    always @(negedge clk) begin
        if (srd && swr) begin
            n_fail++;
            $error("FAIL strobe_overlap: observed srd=%0b swr=%0b expected not both", srd, swr);
        end
    end

endmodule
